// File: rtl/spike_gate_pkg.sv
// Shared types and defaults for the event-triggered spike window gate.
// The counter width helper keeps the top-level parameter math in one place.
package spike_gate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OPEN = 2'd2
    } gate_state_t;

    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_TRIGGERS  = 2;
    localparam int DEF_OPEN      = 3;
    localparam int DEF_CLOSE     = 5;
    localparam int DEF_RETRIGGER = 0;
    localparam int DEF_ONESHOT   = 0;

    // Bits needed to hold 0..close; never narrower than one bit.
    function automatic int cnt_width(input int close);
        return (close < 1) ? 1 : $clog2(close + 1);
    endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Registered rising-edge detector. The history flop clears on reset, so an
// input already high when reset releases reads as an edge on the first clock.
module spike_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_edge
);

    logic in_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= i_in;
        end
    end

    assign o_edge = i_in & ~in_q;

endmodule

// File: rtl/spike_window_gate.sv
// Trigger-started delay/window sequencer that forwards spike rising edges as
// single-cycle pulses while the window is open.
module spike_window_gate
    import spike_gate_pkg::*;
#(
    parameter int P_CHANNELS  = DEF_CHANNELS,
    parameter int P_TRIGGERS  = DEF_TRIGGERS,
    parameter int P_OPEN      = DEF_OPEN,
    parameter int P_CLOSE     = DEF_CLOSE,
    parameter int P_RETRIGGER = DEF_RETRIGGER,
    parameter int P_ONESHOT   = DEF_ONESHOT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [P_TRIGGERS-1:0] i_trigger,
    input  logic [P_CHANNELS-1:0] i_spike,
    output logic [P_CHANNELS-1:0] o_spike,
    output logic                  o_window,
    output logic                  o_busy,
    output logic                  o_overrun
);

    localparam int            CW         = cnt_width(P_CLOSE);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_OPEN   = CW'(P_OPEN);
    localparam logic [CW-1:0] CNT_CLOSE  = CW'(P_CLOSE);
    localparam logic          RETRIG_EN  = (P_RETRIGGER != 0);
    localparam logic          ONESHOT_EN = (P_ONESHOT != 0);

    logic                  trig_any;
    logic                  trig_edge;
    logic [P_CHANNELS-1:0] spk_edge;

    gate_state_t           state_q, state_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  restart;
    logic                  drop;

    logic                  window_n, busy_n, overrun_n;
    logic                  clear_fired;
    logic [P_CHANNELS-1:0] spike_n;
    logic [P_CHANNELS-1:0] fired_q, fired_n;

    assign trig_any = |i_trigger;

    spike_edge_detect u_trig_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (trig_any),
        .o_edge (trig_edge)
    );

    for (genvar c = 0; c < P_CHANNELS; c++) begin : g_spike_edge
        spike_edge_detect u_spike_edge (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_in   (i_spike[c]),
            .o_edge (spk_edge[c])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fired_q   <= '0;
            o_window  <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
            o_spike   <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            fired_q   <= fired_n;
            o_window  <= window_n;
            o_busy    <= busy_n;
            o_overrun <= overrun_n;
            o_spike   <= spike_n;
        end
    end

    // A trigger on the closing cycle always restarts cleanly, whatever the retrigger mode.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        restart = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_edge) restart = 1'b1;
            end
            WAIT: begin
                if (trig_edge && RETRIG_EN) begin
                    restart = 1'b1;
                end else begin
                    drop  = trig_edge;
                    cnt_n = cnt_q + CNT_ONE;
                    if (cnt_q + CNT_ONE == CNT_OPEN) state_n = OPEN;
                end
            end
            OPEN: begin
                if (cnt_q == CNT_CLOSE) begin
                    if (trig_edge) begin
                        restart = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else if (trig_edge && RETRIG_EN) begin
                    restart = 1'b1;
                end else begin
                    drop  = trig_edge;
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (restart) begin
            cnt_n   = CNT_ONE;
            state_n = (P_OPEN == 1) ? OPEN : WAIT;
        end
    end

    // Outputs are single-cycle registered pulses; there is no backpressure.
    always_comb begin
        window_n    = (state_n == OPEN);
        busy_n      = (state_n != IDLE);
        overrun_n   = drop;
        clear_fired = restart || ((state_n == OPEN) && (state_q != OPEN));
        spike_n     = spk_edge & {P_CHANNELS{o_window}}
                      & ~({P_CHANNELS{ONESHOT_EN}} & fired_q);
        fired_n     = clear_fired ? '0 : (fired_q | spike_n);
    end

endmodule

// File: tb/tb_spike_window_gate.sv
// Directed bench for spike_window_gate: three parameter variants, cycle-by-cycle
// expected outputs queued by the driver and compared by an independent monitor.
module tb_spike_window_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] trig_v [3];
    logic [3:0] spk_v  [3];
    logic [3:0] ospk   [3];
    logic       win    [3];
    logic       busy   [3];
    logic       ovr    [3];

    logic [6:0] exp_q[$];
    logic [6:0] exp_v;
    int         sel = 0;
    string      scen = "reset";
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    // dut0: defaults; dut1: retrigger + one-shot; dut2: one-cycle window
    spike_window_gate #(.P_CHANNELS(4), .P_TRIGGERS(2), .P_OPEN(3), .P_CLOSE(5),
                        .P_RETRIGGER(0), .P_ONESHOT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig_v[0]), .i_spike(spk_v[0]),
        .o_spike(ospk[0]), .o_window(win[0]), .o_busy(busy[0]), .o_overrun(ovr[0]));

    spike_window_gate #(.P_CHANNELS(4), .P_TRIGGERS(2), .P_OPEN(3), .P_CLOSE(5),
                        .P_RETRIGGER(1), .P_ONESHOT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig_v[1]), .i_spike(spk_v[1]),
        .o_spike(ospk[1]), .o_window(win[1]), .o_busy(busy[1]), .o_overrun(ovr[1]));

    spike_window_gate #(.P_CHANNELS(4), .P_TRIGGERS(2), .P_OPEN(1), .P_CLOSE(1),
                        .P_RETRIGGER(0), .P_ONESHOT(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig_v[2]), .i_spike(spk_v[2]),
        .o_spike(ospk[2]), .o_window(win[2]), .o_busy(busy[2]), .o_overrun(ovr[2]));

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual {win,busy,ovr,spike}=%b required=%b",
                     name, $time, act, req);
        end
    endtask

    function automatic logic in_rng(input int t, input int a, input int b);
        return (t >= a) && (t <= b);
    endfunction

    // Drive one cycle of inputs on the selected DUT and queue its expected outputs.
    task automatic step(input logic [1:0] trg, input logic [3:0] spk,
                        input logic w, input logic b, input logic o, input logic [3:0] os);
        for (int i = 0; i < 3; i++) begin
            trig_v[i] = (i == sel) ? trg : 2'b00;
            spk_v[i]  = (i == sel) ? spk : 4'b0000;
        end
        exp_q.push_back({w, b, o, os});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check(scen, {win[sel], busy[sel], ovr[sel], ospk[sel]}, exp_v);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] s;
        logic [3:0] os;
        for (int i = 0; i < 3; i++) begin
            trig_v[i] = 2'b00;
            spk_v[i]  = 4'b0000;
        end
        #1;
        for (int i = 0; i < 3; i++)
            check("reset_state", {win[i], busy[i], ovr[i], ospk[i]}, 7'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Trigger at edge 10: window after 12..14, spikes accepted at edges 13..15
        scen = "window_basic"; sel = 0;
        for (int t = 0; t < 20; t++) begin
            s = 4'b0000;
            os = 4'b0000;
            case (t)
                8:  s = 4'b1111;
                12: s = 4'b0010;
                13: s = 4'b0101;
                15: s = 4'b0100;
                16: s = 4'b1000;
                default: ;
            endcase
            if (t == 13) os = 4'b0101;
            if (t == 15) os = 4'b0100;
            step((t == 10) ? 2'b01 : 2'b00, s, in_rng(t, 12, 14), in_rng(t, 10, 14), 1'b0, os);
        end

        // Second edge at cnt==2 without retrigger: dropped and flagged
        scen = "overrun"; sel = 0;
        for (int t = 0; t < 8; t++)
            step((t == 0) ? 2'b10 : ((t == 2) ? 2'b01 : 2'b00), 4'b0000,
                 in_rng(t, 2, 4), in_rng(t, 0, 4), (t == 2), 4'b0000);

        // Edge on the closing cycle restarts with busy held high
        scen = "close_restart"; sel = 0;
        for (int t = 0; t < 12; t++)
            step((t == 0 || t == 5) ? 2'b01 : 2'b00, 4'b0000,
                 in_rng(t, 2, 4) || in_rng(t, 7, 9), in_rng(t, 0, 9), 1'b0, 4'b0000);

        // Async reset mid-window, then trigger held through release
        scen = "reset_mid"; sel = 0;
        for (int t = 0; t < 4; t++)
            step((t == 0) ? 2'b01 : 2'b00, 4'b0000, in_rng(t, 2, 3), in_rng(t, 0, 3), 1'b0, 4'b0000);
        #2;
        rst = 1'b1;
        trig_v[0] = 2'b11;
        #1;
        check("async_reset", {win[0], busy[0], ovr[0], ospk[0]}, 7'b0);
        @(negedge clk);
        rst = 1'b0;
        scen = "trig_held_reset"; sel = 0;
        for (int t = 0; t < 7; t++)
            step(2'b11, 4'b0000, in_rng(t, 2, 4), in_rng(t, 0, 4), 1'b0, 4'b0000);
        idle(2);

        // One-shot: second ch0 edge in a window is blocked, next window re-arms
        scen = "oneshot"; sel = 1;
        for (int t = 0; t < 16; t++) begin
            s = 4'b0000;
            os = 4'b0000;
            case (t)
                3, 5, 11: s = 4'b0001;
                13:       s = 4'b0011;
                default: ;
            endcase
            if (t == 3 || t == 11) os = 4'b0001;
            if (t == 13) os = 4'b0010;
            step((t == 0 || t == 8) ? 2'b01 : 2'b00, s,
                 in_rng(t, 2, 4) || in_rng(t, 10, 12), in_rng(t, 0, 4) || in_rng(t, 8, 12), 1'b0, os);
        end

        // Retrigger at cnt==2 restarts the count: window shifts by two cycles
        scen = "retrigger"; sel = 1;
        for (int t = 0; t < 10; t++)
            step((t == 0 || t == 2) ? 2'b01 : 2'b00, 4'b0000,
                 in_rng(t, 4, 6), in_rng(t, 0, 6), 1'b0, 4'b0000);

        // P_OPEN == P_CLOSE == 1: single-cycle window, spike on the closing edge forwarded
        scen = "one_cycle_window"; sel = 2;
        for (int t = 0; t < 8; t++) begin
            s = 4'b0000;
            os = 4'b0000;
            case (t)
                1: begin s = 4'b1000; os = 4'b1000; end
                4: begin s = 4'b0001; os = 4'b0001; end
                default: ;
            endcase
            step((t == 0 || t == 1) ? 2'b01 : ((t == 3) ? 2'b10 : 2'b00), s,
                 (t == 0 || t == 3), (t == 0 || t == 3), 1'b0, os);
        end

        check("queue_drain", 7'(exp_q.size()), 7'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
